bus_arbiter: RTL

- Central arbiter for the shared master bus; the granting end of the request/grant handshake that each master drives.
- Samples request lines from up to NUM_MASTERS masters and drives an encoded grant id; id 0 means the bus is idle.
- Holds each grant for a fixed tenure, then inserts one idle cycle.
- On the final grant cycle it samples the shared data bus and presents the captured word with a one-cycle valid strobe.

---
 rtl/bus_arbiter_if.sv | 31 +++
 rtl/bus_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_if : request/grant/capture bundle shared by masters and arbiter.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface bus_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int GRANT_W     = 3,
  parameter int DATA_W      = 5
);
  logic [NUM_MASTERS-1:0] request;
  logic [DATA_W-1:0]      data;
  logic [GRANT_W-1:0]     grant;
  logic                   busy;
  logic [DATA_W-1:0]      captured_data;
  logic                   captured_valid;
  logic [GRANT_W-1:0]     captured_id;

  modport slave (
    input  request, data,
    output grant, busy, captured_data, captured_valid, captured_id
  );

  modport master (
    output request, data,
    input  grant, busy, captured_data, captured_valid, captured_id
  );
endinterface

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter : round-robin bus arbiter with fixed tenure, release gap and
// final-cycle data capture. Macro ARB_FIXED_PRIORITY_EN selects lowest-id wins.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int GRANT_W     = 3,
  parameter int DATA_W      = 5,
  parameter int HOLD_CYCLES = 3
) (
  input wire logic     clk,
  input wire logic     rst_n,
  bus_arbiter_if.slave bus
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int RR_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [CNT_W-1:0] C_HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [GRANT_W-1:0]  grant_q, grant_nx;
  logic                busy_q;
  logic [CNT_W-1:0]    cnt_q, cnt_nx;
  logic [DATA_W-1:0]   cap_data_q, cap_data_nx;
  logic                cap_valid_q, cap_valid_nx;
  logic [GRANT_W-1:0]  cap_id_q, cap_id_nx;

  logic                owner_req;
  logic                lo_found;
  logic [GRANT_W-1:0]  lo_idx;
  logic [GRANT_W-1:0]  win_idx;

`ifndef ARB_FIXED_PRIORITY_EN
  logic [RR_W-1:0]     rr_q, rr_nx;
  logic [RR_W-1:0]     owner_next;
  logic                hi_found;
  logic [GRANT_W-1:0]  hi_idx;
`endif

  // Owner request bit and the pointer slot just past the owner
  always_comb begin
    owner_req = 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
    owner_next = '0;
`endif
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q == GRANT_W'(i + 1)) begin
        owner_req = bus.request[i];
`ifndef ARB_FIXED_PRIORITY_EN
        owner_next = (i == NUM_MASTERS - 1) ? '0 : RR_W'(i + 1);
`endif
      end
    end
  end

  // Winner: first set bit at/after rr pointer, else lowest set bit (wrap)
  always_comb begin
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!lo_found && bus.request[i]) begin
        lo_found = 1'b1;
        lo_idx   = GRANT_W'(i);
      end
    end
`ifndef ARB_FIXED_PRIORITY_EN
    hi_found = 1'b0;
    hi_idx   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!hi_found && bus.request[i] && (RR_W'(i) >= rr_q)) begin
        hi_found = 1'b1;
        hi_idx   = GRANT_W'(i);
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
`else
    win_idx = lo_idx;
`endif
  end

  always_comb begin
    state_nx     = state;
    grant_nx     = grant_q;
    cnt_nx       = cnt_q;
    cap_data_nx  = cap_data_q;
    cap_valid_nx = 1'b0;
    cap_id_nx    = cap_id_q;
`ifndef ARB_FIXED_PRIORITY_EN
    rr_nx        = rr_q;
`endif
    case (state)
      S_IDLE: begin
        if (|bus.request) begin
          grant_nx = win_idx + GRANT_W'(1);
          cnt_nx   = C_HOLD_LOAD;
          state_nx = S_GRANT;
        end
      end
      S_GRANT: begin
        // A dropped request takes precedence over a terminal count: no capture
        if (!owner_req || cnt_q == '0) begin
          if (owner_req) begin
            cap_data_nx  = bus.data;
            cap_id_nx    = grant_q;
            cap_valid_nx = 1'b1;
          end
          grant_nx = '0;
`ifndef ARB_FIXED_PRIORITY_EN
          rr_nx    = owner_next;
`endif
          state_nx = S_RELEASE;
        end else begin
          cnt_nx = cnt_q - CNT_W'(1);
        end
      end
      S_RELEASE: state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      cap_data_q  <= '0;
      cap_valid_q <= 1'b0;
      cap_id_q    <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
      rr_q        <= '0;
`endif
    end else begin
      state       <= state_nx;
      grant_q     <= grant_nx;
      busy_q      <= (grant_nx != '0);
      cnt_q       <= cnt_nx;
      cap_data_q  <= cap_data_nx;
      cap_valid_q <= cap_valid_nx;
      cap_id_q    <= cap_id_nx;
`ifndef ARB_FIXED_PRIORITY_EN
      rr_q        <= rr_nx;
`endif
    end
  end

  assign bus.grant          = grant_q;
  assign bus.busy           = busy_q;
  assign bus.captured_data  = cap_data_q;
  assign bus.captured_valid = cap_valid_q;
  assign bus.captured_id    = cap_id_q;

endmodule

`default_nettype wire
